// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch-stage bundle: instruction RAM read port, redirect input, decode handshake
interface ifetch_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic [ADDR_WIDTH-1:0] icache_rd_addr;
  logic [DATA_WIDTH-1:0] icache_rd_data;
  logic                  redirect_valid;
  logic [PC_WIDTH-1:0]   redirect_pc;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst_data;
  logic [PC_WIDTH-1:0]   inst_pc;
  logic                  inst_ready;

  // fetch unit side
  modport master (
    output icache_rd_addr,
    input  icache_rd_data,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  // RAM / decode / redirect-source side
  modport slave (
    input  icache_rd_addr,
    output icache_rd_data,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: PC, RAM addressing, 2-entry output buffer, redirect flush
module ifetch_unit #(
  parameter int                 ADDR_WIDTH = 10,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input logic          clk,
  input logic          rst,
  ifetch_unit_if.master bus
);

  // Word-aligned PCs: the low two byte-address bits never reach the datapath.
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
  localparam logic [PC_WIDTH-1:0] START_PC   = RESET_PC & ALIGN_MASK;
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);

  // Fetch state: next PC to request, and the PC of the word the RAM returns this cycle.
  logic [PC_WIDTH-1:0]   fetch_pc;
  logic                  inflight;
  logic [PC_WIDTH-1:0]   f1_pc;

  // Output buffer as a shift pair: head always feeds the decode outputs directly.
  logic [PC_WIDTH-1:0]   head_pc;
  logic [DATA_WIDTH-1:0] head_data;
  logic [PC_WIDTH-1:0]   tail_pc;
  logic [DATA_WIDTH-1:0] tail_data;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [2:0]            occupancy;
  logic [PC_WIDTH-1:0]   redirect_target;

  assign bus.icache_rd_addr = fetch_pc[ADDR_WIDTH+1:2];
  assign bus.inst_valid     = (count != 2'd0);
  assign bus.inst_pc        = head_pc;
  assign bus.inst_data      = head_data;

  assign redirect_target = bus.redirect_pc & ALIGN_MASK;

  assign pop  = bus.inst_valid && bus.inst_ready;
  assign push = inflight && !bus.redirect_valid;

  // Slots that will be claimed after this edge: buffered + returning - consumed.
  // A new request is only made when that still leaves room for its word.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = !rst && !bus.redirect_valid && (occupancy < 3'd2);

  // Program counter and in-flight tracking; redirect restarts fetch and drops the pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= START_PC;
      inflight <= 1'b0;
      f1_pc    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        f1_pc    <= fetch_pc;
        fetch_pc <= fetch_pc + PC_STEP;
      end
    end
  end

  // Output buffer: capture returning words in order; redirect empties it, head shifts on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      head_pc   <= '0;
      head_data <= '0;
      tail_pc   <= '0;
      tail_data <= '0;
    end else if (bus.redirect_valid) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc   <= f1_pc;
            head_data <= bus.icache_rd_data;
          end else begin
            tail_pc   <= f1_pc;
            tail_data <= bus.icache_rd_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc   <= tail_pc;
          head_data <= tail_data;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc   <= f1_pc;
            head_data <= bus.icache_rd_data;
          end else begin
            head_pc   <= tail_pc;
            head_data <= tail_data;
            tail_pc   <= f1_pc;
            tail_data <= bus.icache_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - self-checking bench for ifetch_unit
module tb_ifetch_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ifetch_unit_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .PC_WIDTH(32)) bus ();

  ifetch_unit #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .PC_WIDTH  (32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [1024];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction RAM: synchronous read, data visible the cycle after the address.
  always @(posedge clk) bus.icache_rd_data <= mem[bus.icache_rd_addr];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic        chk_pd;
    logic [31:0] e_pc;
    logic [31:0] e_data;
    logic [9:0]  e_addr;
  } vec_t;

  vec_t vt [26];

  function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic cpd, input logic [31:0] epc,
                              input logic [31:0] edata, input logic [9:0] eaddr);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_valid = ev; v.chk_pd = cpd; v.e_pc = epc; v.e_data = edata; v.e_addr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, want);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst                = r;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          since;
    int          ndeliv;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;

    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;

    rst                = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Vector table: reset release streaming 16 words, then a misaligned redirect that wraps the RAM.
    vt[0] = mk(1, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      if (k < 2) vt[1+k] = mk(0, 1, 0, 0, 0, 1, 0, 0, 10'(k));
      else       vt[1+k] = mk(0, 1, 0, 0, 1, 1, 32'(4*(k-2)), 32'hA000_0000 + 32'(k-2), 10'(k));
    end
    vt[19] = mk(0, 1, 1, 32'h0000_0FFB, 1, 1, 32'd64, 32'hA000_0010, 10'd18);
    vt[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'd1022);
    vt[21] = mk(0, 1, 0, 0, 0, 0, 0, 0, 10'd1023);
    vt[22] = mk(0, 1, 0, 0, 1, 1, 32'h0000_0FF8, 32'hA000_03FE, 10'd0);
    vt[23] = mk(0, 1, 0, 0, 1, 1, 32'h0000_0FFC, 32'hA000_03FF, 10'd1);
    vt[24] = mk(0, 1, 0, 0, 1, 1, 32'h0000_1000, 32'hA000_0000, 10'd2);
    vt[25] = mk(0, 1, 0, 0, 1, 1, 32'h0000_1004, 32'hA000_0001, 10'd3);

    repeat (3) step(1, 1, 0, 0);

    for (int i = 0; i < 26; i++) begin
      step(vt[i].rst, vt[i].rdy, vt[i].rv, vt[i].rpc);
      chk("vec_valid", i, 32'(bus.inst_valid), 32'(vt[i].e_valid));
      chk("vec_addr", i, 32'(bus.icache_rd_addr), 32'(vt[i].e_addr));
      if (vt[i].chk_pd) begin
        chk("vec_pc", i, bus.inst_pc, vt[i].e_pc);
        chk("vec_data", i, bus.inst_data, vt[i].e_data);
      end
    end

    // Backpressure, redirect over a full buffer, then reset over a full buffer.
    step(1, 1, 0, 0);
    for (int k = 0; k < 29; k++) begin
      rdy = !((k >= 4 && k <= 8) || (k >= 13 && k <= 16) || (k >= 21 && k <= 25));
      step(k == 25, rdy, k == 16, 32'h0000_0103);
      if (k >= 4 && k <= 8) begin
        chk("bp_valid", k, 32'(bus.inst_valid), 32'd1);
        chk("bp_pc", k, bus.inst_pc, 32'd8);
        chk("bp_data", k, bus.inst_data, 32'hA000_0002);
        chk("bp_addr", k, 32'(bus.icache_rd_addr), 32'd4);
      end
      if (k >= 9 && k <= 12) begin
        chk("resume_valid", k, 32'(bus.inst_valid), 32'd1);
        chk("resume_pc", k, bus.inst_pc, 32'(8 + 4*(k-9)));
        chk("resume_data", k, bus.inst_data, 32'hA000_0002 + 32'(k-9));
      end
      if (k >= 13 && k <= 16) chk("full_pc", k, bus.inst_pc, 32'd24);
      if (k == 17 || k == 18) chk("redir_gap", k, 32'(bus.inst_valid), 32'd0);
      if (k == 19 || k == 20) begin
        chk("redir_valid", k, 32'(bus.inst_valid), 32'd1);
        chk("redir_pc", k, bus.inst_pc, 32'h100 + 32'(4*(k-19)));
        chk("redir_data", k, bus.inst_data, 32'hA000_0040 + 32'(k-19));
      end
      if (k >= 21 && k <= 24) chk("full2_pc", k, bus.inst_pc, 32'h108);
      if (k == 26) begin
        chk("rst_valid", k, 32'(bus.inst_valid), 32'd0);
        chk("rst_pc", k, bus.inst_pc, 32'd0);
        chk("rst_data", k, bus.inst_data, 32'd0);
        chk("rst_addr", k, 32'(bus.icache_rd_addr), 32'd0);
      end
      if (k == 27) chk("rst_gap", k, 32'(bus.inst_valid), 32'd0);
      if (k == 28) begin
        chk("restart_valid", k, 32'(bus.inst_valid), 32'd1);
        chk("restart_pc", k, bus.inst_pc, 32'd0);
        chk("restart_data", k, bus.inst_data, 32'hA000_0000);
      end
    end

    // Random ready and redirects against a stream model: next expected PC plus restart latency.
    step(1, 1, 0, 0);
    exp_pc = 32'd0;
    since  = 0;
    ndeliv = 0;
    for (int c = 0; c < 2000; c++) begin
      rdy = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 31) == 0);
      rpc = $urandom;
      step(0, rdy, rv, rpc);
      if (since < 100) since++;
      chk("rand_valid", c, 32'(bus.inst_valid), 32'(since >= 3));
      if (bus.inst_valid) begin
        chk("rand_pc", c, bus.inst_pc, exp_pc);
        chk("rand_data", c, bus.inst_data, mem[exp_pc[11:2]]);
        if (rdy) begin
          exp_pc = exp_pc + 32'd4;
          ndeliv++;
        end
      end
      if (rv) begin
        exp_pc = rpc & ~32'd3;
        since  = 0;
      end
    end
    chk("rand_deliveries", 0, 32'(ndeliv > 500), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
